feature_fetch: RTL and testbench

Requester-side controller for the Haar feature ROM. It takes a feature index from the cascade evaluator and issues the four sequential synchronous reads that make up one feature record. It captures the header and three rectangle words and presents the assembled record on a valid/ready output. It sits between the stage/classifier sequencer and the feature ROM, and is the only block that drives the ROM address.

---
 rtl/feature_pkg.sv | 46 ++++
 rtl/feature_fetch.sv | 188 ++++++++++++++++++
 tb/tb_feature_fetch.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/feature_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : feature_pkg
//  Description : Shared constants and types for the Haar feature record
//                format. Used by the feature fetcher, the classifier and
//                the rect-sum unit so all agree on field positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package feature_pkg;

    // Record geometry: one header word followed by three rectangle words.
    localparam int c_REC_STRIDE   = 4;
    localparam int c_REC_SHIFT    = 2;     // log2(c_REC_STRIDE)
    localparam int c_NUM_RECTS    = 3;

    // Header word: rectangle count field.
    localparam int c_HDR_CNT_MSB  = 1;
    localparam int c_HDR_CNT_LSB  = 0;

    // Rectangle word fields.
    localparam int c_X_MSB        = 31;
    localparam int c_X_LSB        = 26;
    localparam int c_Y_MSB        = 25;
    localparam int c_Y_LSB        = 20;
    localparam int c_W_MSB        = 19;
    localparam int c_W_LSB        = 14;
    localparam int c_H_MSB        = 13;
    localparam int c_H_LSB        = 8;
    localparam int c_WT_MSB       = 7;
    localparam int c_WT_LSB       = 0;

    // Fetch controller states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } fetch_state_e;

    // A feature record legally carries two or three rectangles.
    function automatic logic count_is_legal(input logic [1:0] cnt);
        return (cnt == 2'd2) || (cnt == 2'd3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/feature_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : feature_fetch
//  Description : Requester-side controller for the Haar feature ROM. Accepts
//                a feature index, issues four sequential reads (header plus
//                three rectangles), captures the returned words and presents
//                the assembled record on a valid/ready output.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk        in   clock, rising edge
//    rst        in   asynchronous active-high reset
//    req_valid  in   feature request present
//    req_ready  out  idle, request can be accepted
//    req_index  in   feature number (sampled on acceptance only)
//    rom_addr   out  registered ROM read address
//    rom_data   in   ROM data, one clk after address is sampled
//    out_valid  out  assembled record available
//    out_ready  in   consumer accepts record
//    out_count  out  header rectangle count
//    out_rects  out  {rect2, rect1, rect0}
//    out_err    out  header count is not 2 or 3
// ============================================================================
module feature_fetch
    import feature_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 14,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    IDX_W        = 10,
    parameter logic [ADDR_WIDTH-1:0] FEATURE_BASE = 14'h1770
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [IDX_W-1:0]          req_index,
    output logic [ADDR_WIDTH-1:0]     rom_addr,
    input  logic [DATA_WIDTH-1:0]     rom_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [1:0]                out_count,
    output logic [3*DATA_WIDTH-1:0]   out_rects,
    output logic                      out_err
);

    // Offset arithmetic is done wide enough to hold the shifted index, then
    // truncated so the base address wraps modulo 2^ADDR_WIDTH.
    localparam int c_EXT_W = (ADDR_WIDTH > IDX_W + c_REC_SHIFT) ?
                             ADDR_WIDTH : (IDX_W + c_REC_SHIFT);

    fetch_state_e              r_state_q,    w_state_d;
    logic [ADDR_WIDTH-1:0]     r_base_q,     w_base_d;
    logic [ADDR_WIDTH-1:0]     r_rom_addr_q, w_rom_addr_d;
    logic [1:0]                r_iss_cnt_q,  w_iss_cnt_d;
    logic [1:0]                r_cap_cnt_q,  w_cap_cnt_d;
    logic [1:0]                r_pipe_q,     w_pipe_d;
    logic [1:0]                r_hdr_cnt_q,  w_hdr_cnt_d;
    logic                      r_err_q,      w_err_d;
    logic [DATA_WIDTH-1:0]     r_rect0_q,    w_rect0_d;
    logic [DATA_WIDTH-1:0]     r_rect1_q,    w_rect1_d;
    logic [DATA_WIDTH-1:0]     r_rect2_q,    w_rect2_d;

    logic [c_EXT_W-1:0]        w_offset;
    logic [ADDR_WIDTH-1:0]     w_req_base;
    logic                      w_issue;
    logic [1:0]                w_rom_cnt;

    assign w_offset   = c_EXT_W'(req_index) << c_REC_SHIFT;
    assign w_req_base = FEATURE_BASE + w_offset[ADDR_WIDTH-1:0];
    assign w_rom_cnt  = rom_data[c_HDR_CNT_MSB:c_HDR_CNT_LSB];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d    = r_state_q;
        w_base_d     = r_base_q;
        w_rom_addr_d = r_rom_addr_q;
        w_iss_cnt_d  = r_iss_cnt_q;
        w_cap_cnt_d  = r_cap_cnt_q;
        w_hdr_cnt_d  = r_hdr_cnt_q;
        w_err_d      = r_err_q;
        w_rect0_d    = r_rect0_q;
        w_rect1_d    = r_rect1_q;
        w_rect2_d    = r_rect2_q;
        w_issue      = 1'b0;

        case (r_state_q)
            IDLE: begin
                // req_ready is high in IDLE, so req_valid alone is acceptance.
                if (req_valid) begin
                    w_base_d     = w_req_base;
                    w_rom_addr_d = w_req_base;
                    w_iss_cnt_d  = 2'd1;
                    w_cap_cnt_d  = 2'd0;
                    w_issue      = 1'b1;
                    w_state_d    = ISSUE;
                end
            end
            ISSUE: begin
                w_rom_addr_d = r_base_q + ADDR_WIDTH'(r_iss_cnt_q);
                w_iss_cnt_d  = r_iss_cnt_q + 2'd1;
                w_issue      = 1'b1;
                if (r_iss_cnt_q == 2'd3) begin
                    w_state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (r_pipe_q[1] && (r_cap_cnt_q == 2'd3)) begin
                    w_state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        // Capture runs independently of the issue state: a word returns
        // two edges after its address was registered (one to reach the
        // ROM, one for the ROM's own register), so it overlaps ISSUE.
        if (r_pipe_q[1]) begin
            w_cap_cnt_d = r_cap_cnt_q + 2'd1;
            case (r_cap_cnt_q)
                2'd0: begin
                    w_hdr_cnt_d = w_rom_cnt;
                    w_err_d     = ~count_is_legal(w_rom_cnt);
                end
                2'd1:    w_rect0_d = rom_data;
                2'd2:    w_rect1_d = rom_data;
                default: w_rect2_d = rom_data;
            endcase
        end

        w_pipe_d = {r_pipe_q[0], w_issue};
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q    <= IDLE;
            r_base_q     <= '0;
            r_rom_addr_q <= '0;
            r_iss_cnt_q  <= 2'd0;
            r_cap_cnt_q  <= 2'd0;
            r_pipe_q     <= 2'd0;
            r_hdr_cnt_q  <= 2'd0;
            r_err_q      <= 1'b0;
            r_rect0_q    <= '0;
            r_rect1_q    <= '0;
            r_rect2_q    <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_base_q     <= w_base_d;
            r_rom_addr_q <= w_rom_addr_d;
            r_iss_cnt_q  <= w_iss_cnt_d;
            r_cap_cnt_q  <= w_cap_cnt_d;
            r_pipe_q     <= w_pipe_d;
            r_hdr_cnt_q  <= w_hdr_cnt_d;
            r_err_q      <= w_err_d;
            r_rect0_q    <= w_rect0_d;
            r_rect1_q    <= w_rect1_d;
            r_rect2_q    <= w_rect2_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready = (r_state_q == IDLE);
    assign out_valid = (r_state_q == DONE);
    assign rom_addr  = r_rom_addr_q;
    assign out_count = r_hdr_cnt_q;
    assign out_err   = r_err_q;

    // A two-rectangle record carries a don't-care third word; blank it so
    // downstream sums never pick up stale data.
    assign out_rects = {((r_hdr_cnt_q == 2'd2) ? {DATA_WIDTH{1'b0}} : r_rect2_q),
                        r_rect1_q, r_rect0_q};

endmodule
`default_nettype wire

// File: tb/tb_feature_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_feature_fetch
//  Description : Self-checking bench for feature_fetch with behavioural
//                1-cycle synchronous ROM models. Expected records are queued
//                by the stimulus and checked by a separate monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_feature_fetch;

    typedef struct packed {
        logic [1:0]  cnt;
        logic [95:0] rects;
        logic        err;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;
    rec_t exp_q[$];

    // DUT A: default base
    logic        a_req_valid = 1'b0;
    logic        a_req_ready;
    logic [9:0]  a_req_index = '0;
    logic [13:0] a_rom_addr;
    logic [31:0] a_rom_data;
    logic        a_out_valid;
    logic        a_out_ready = 1'b0;
    logic [1:0]  a_out_count;
    logic [95:0] a_out_rects;
    logic        a_out_err;

    // DUT B: base near top of address space
    logic        b_req_valid = 1'b0;
    logic        b_req_ready;
    logic [9:0]  b_req_index = '0;
    logic [13:0] b_rom_addr;
    logic [31:0] b_rom_data;
    logic        b_out_valid;
    logic        b_out_ready = 1'b0;
    logic [1:0]  b_out_count;
    logic [95:0] b_out_rects;
    logic        b_out_err;

    logic [31:0] mem_a [0:16383];
    logic [31:0] mem_b [0:16383];

    always @(posedge clk) a_rom_data <= mem_a[a_rom_addr];
    always @(posedge clk) b_rom_data <= mem_b[b_rom_addr];

    feature_fetch u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .req_valid (a_req_valid),
        .req_ready (a_req_ready),
        .req_index (a_req_index),
        .rom_addr  (a_rom_addr),
        .rom_data  (a_rom_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_count (a_out_count),
        .out_rects (a_out_rects),
        .out_err   (a_out_err)
    );

    feature_fetch #(.FEATURE_BASE(14'h3FFE)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .req_valid (b_req_valid),
        .req_ready (b_req_ready),
        .req_index (b_req_index),
        .rom_addr  (b_rom_addr),
        .rom_data  (b_rom_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_count (b_out_count),
        .out_rects (b_out_rects),
        .out_err   (b_out_err)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a transfer is visible at the negedge before the
    // edge that completes it.
    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            rec_t e;
            xfers++;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_record", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_count", a_out_count, e.cnt);
                chk("sb_rects", a_out_rects, e.rects);
                chk("sb_err",   a_out_err,   e.err);
            end
        end
    end

    // Issue one request to DUT A. Entered and left just after a posedge.
    task automatic run_fetch(input logic [9:0] idx, input int hold, input rec_t exp);
        logic [13:0] base;
        logic [95:0] s_rects;
        logic [1:0]  s_cnt;
        logic        s_err;
        base = 14'h1770 + {2'b00, idx, 2'b00};
        exp_q.push_back(exp);
        a_req_valid = 1'b1;
        a_req_index = idx;
        a_out_ready = (hold == 0);
        @(posedge clk); #1;                     // E0 acceptance
        a_req_valid = 1'b0;
        a_req_index = ~idx;                     // must be ignored from here on
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);                     // after E(c)
            chk("addr_step", a_rom_addr, (c < 4) ? base + 14'(c) : base + 14'd3);
            chk("valid_latency", a_out_valid, (c == 5));
            chk("req_ready_busy", a_req_ready, 1'b0);
        end
        if (hold > 0) begin
            s_rects = a_out_rects;
            s_cnt   = a_out_count;
            s_err   = a_out_err;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("bp_valid",  a_out_valid, 1'b1);
                chk("bp_rects",  a_out_rects, s_rects);
                chk("bp_count",  a_out_count, s_cnt);
                chk("bp_err",    a_out_err,   s_err);
                chk("bp_ready",  a_req_ready, 1'b0);
                chk("bp_addr",   a_rom_addr,  base + 14'd3);
            end
            @(posedge clk); #1;
            a_out_ready = 1'b1;
        end
        @(posedge clk); #1;                     // transfer edge
        chk("req_ready_after_xfer", a_req_ready, 1'b1);
        chk("valid_after_xfer",     a_out_valid, 1'b0);
        a_out_ready = 1'b0;
    endtask

    task automatic chk_reset_vals;
        chk("rst_req_ready", a_req_ready, 1'b1);
        chk("rst_rom_addr",  a_rom_addr,  14'h0);
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_out_count", a_out_count, 2'd0);
        chk("rst_out_rects", a_out_rects, 96'h0);
        chk("rst_out_err",   a_out_err,   1'b0);
    endtask

    logic [13:0] wrap_exp [4] = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        // index 0: basic three-rect record
        mem_a[6000] = 32'h3;          mem_a[6001] = 32'hA1B2C3D4;
        mem_a[6002] = 32'h11223344;   mem_a[6003] = 32'h55667788;
        // index 1: two-rect record, third word must be blanked
        mem_a[6004] = 32'h2;          mem_a[6005] = 32'hDEADBEEF;
        mem_a[6006] = 32'h01020304;   mem_a[6007] = 32'hFFFFFFFF;
        // index 2: backpressure record
        mem_a[6008] = 32'h3;          mem_a[6009] = 32'h12345678;
        mem_a[6010] = 32'h9ABCDEF0;   mem_a[6011] = 32'h0F0F0F0F;
        // index 3: count 1 with reserved header bits set
        mem_a[6012] = 32'hFFFFFFF1;   mem_a[6013] = 32'hAAAA0001;
        mem_a[6014] = 32'hBBBB0002;   mem_a[6015] = 32'hCCCC0003;
        // index 4: count 0
        mem_a[6016] = 32'h0;          mem_a[6017] = 32'h00000011;
        mem_a[6018] = 32'h00000022;   mem_a[6019] = 32'h00000033;
        // index 5: target of the aborted fetch
        mem_a[6020] = 32'h3;          mem_a[6021] = 32'h77777777;
        mem_a[6022] = 32'h88888888;   mem_a[6023] = 32'h99999999;
        // DUT B wrap record
        mem_b[14'h3FFE] = 32'h3;      mem_b[14'h3FFF] = 32'h11111111;
        mem_b[14'h0000] = 32'h22222222; mem_b[14'h0001] = 32'h33333333;

        #1;
        chk_reset_vals();
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        run_fetch(10'd0, 0, '{cnt: 2'd3, rects: {32'h55667788, 32'h11223344, 32'hA1B2C3D4}, err: 1'b0});
        run_fetch(10'd1, 0, '{cnt: 2'd2, rects: {32'h00000000, 32'h01020304, 32'hDEADBEEF}, err: 1'b0});
        run_fetch(10'd2, 10, '{cnt: 2'd3, rects: {32'h0F0F0F0F, 32'h9ABCDEF0, 32'h12345678}, err: 1'b0});
        run_fetch(10'd3, 0, '{cnt: 2'd1, rects: {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001}, err: 1'b1});
        run_fetch(10'd4, 2, '{cnt: 2'd0, rects: {32'h00000033, 32'h00000022, 32'h00000011}, err: 1'b1});

        // Wrap on DUT B
        b_req_valid = 1'b1;
        b_req_index = 10'd0;
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 4) chk("wrap_addr", b_rom_addr, wrap_exp[c]);
            chk("wrap_valid", b_out_valid, (c == 5));
        end
        chk("wrap_count", b_out_count, 2'd3);
        chk("wrap_rects", b_out_rects, {32'h33333333, 32'h22222222, 32'h11111111});
        chk("wrap_err",   b_out_err,   1'b0);
        @(posedge clk); #1;
        chk("wrap_ready_back", b_req_ready, 1'b1);
        b_out_ready = 1'b0;

        // Reset two cycles after acceptance
        a_req_valid = 1'b1;
        a_req_index = 10'd5;
        a_out_ready = 1'b1;
        @(posedge clk); #1;                     // E0
        a_req_valid = 1'b0;
        @(posedge clk); #1;                     // E1
        @(posedge clk); #2;                     // E2
        rst = 1'b1;
        #1;
        chk_reset_vals();
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("no_valid_after_rst", a_out_valid, 1'b0);
        end
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        run_fetch(10'd0, 0, '{cnt: 2'd3, rects: {32'h55667788, 32'h11223344, 32'hA1B2C3D4}, err: 1'b0});

        repeat (2) @(posedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        chk("xfer_total", 32'(xfers), 32'd6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
